// File: rtl/nios_pio_pulse_out.sv
// Avalon-MM output PIO with set/clear/pulse registers. Bits written through the
// PULSE register are held high for PULSE_CYCLES clocks and then cleared by a
// small timer FSM, so software never has to poll to end a relay/LED pulse.
module nios_pio_pulse_out #(
  parameter int unsigned                 DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0]       RESET_VALUE  = '0,
  parameter int unsigned                 PULSE_CYCLES = 1000,
  parameter int unsigned                 CNT_WIDTH    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [1:0]            i_address,
  input  logic                  i_chipselect,
  input  logic                  i_write_n,
  input  logic [31:0]           i_writedata,
  output logic [31:0]           o_readdata,
  output logic [DATA_WIDTH-1:0] o_out_port,
  output logic                  o_pulse_busy
);

  localparam logic [CNT_WIDTH-1:0] LP_CNT_LOAD = CNT_WIDTH'(PULSE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [0:0] {StIdle, StPulsing} state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_out_port;
  logic [DATA_WIDTH-1:0] w_out_nxt;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] w_mask_nxt;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic [31:0]           r_readdata;
  logic [31:0]           w_rd_nxt;

  logic                  w_wr;
  logic                  w_pulse_wr;
  logic                  w_pulsing;
  logic                  w_expire;
  logic [DATA_WIDTH-1:0] w_wd;
  logic                  w_unused_wd;

  assign w_wr        = i_chipselect & ~i_write_n;
  assign w_wd        = i_writedata[DATA_WIDTH-1:0];
  assign w_unused_wd = ^i_writedata;
  assign w_pulse_wr  = w_wr && (i_address == 2'd3) && (w_wd != '0);
  assign w_pulsing   = (r_state == StPulsing);
  assign w_expire    = w_pulsing && (r_count == LP_CNT_ONE);

  // Next state for pins, pulse mask, timer and FSM. Register writes apply
  // first; expiry then clears whatever mask bits remain.
  always_comb begin
    w_out_nxt   = r_out_port;
    w_mask_nxt  = r_mask;
    w_cnt_nxt   = r_count;
    w_state_nxt = r_state;

    if (w_wr) begin
      case (i_address)
        2'd0: w_out_nxt = w_wd;
        2'd1: w_out_nxt = r_out_port | w_wd;
        2'd2: begin
          w_out_nxt  = r_out_port & ~w_wd;
          w_mask_nxt = r_mask & ~w_wd;
        end
        default: ;
      endcase
    end

    if (w_pulse_wr) begin
      // A new pulse beats an expiring one: only old bits not re-pulsed drop.
      w_out_nxt   = (w_expire ? (r_out_port & ~r_mask) : r_out_port) | w_wd;
      w_mask_nxt  = (w_expire ? '0 : r_mask) | w_wd;
      w_cnt_nxt   = LP_CNT_LOAD;
      w_state_nxt = StPulsing;
    end else if (w_expire) begin
      w_out_nxt   = w_out_nxt & ~r_mask;
      w_mask_nxt  = '0;
      w_cnt_nxt   = '0;
      w_state_nxt = StIdle;
    end else if (w_pulsing) begin
      if (w_mask_nxt == '0) begin
        // Every pulsed bit was cleared by software; stop the timer early.
        w_cnt_nxt   = '0;
        w_state_nxt = StIdle;
      end else begin
        w_cnt_nxt = r_count - LP_CNT_ONE;
      end
    end
  end

  // Read mux, sampled every clock irrespective of chipselect.
  always_comb begin
    w_rd_nxt = '0;
    case (i_address)
      2'd0: w_rd_nxt[DATA_WIDTH-1:0] = r_out_port;
      2'd3: begin
        w_rd_nxt[CNT_WIDTH-1:0] = r_count;
        w_rd_nxt[31]            = w_pulsing;
      end
      default: ;
    endcase
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_out_port <= RESET_VALUE;
      r_mask     <= '0;
      r_count    <= '0;
      r_readdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_out_port <= w_out_nxt;
      r_mask     <= w_mask_nxt;
      r_count    <= w_cnt_nxt;
      r_readdata <= w_rd_nxt;
    end
  end

  assign o_out_port   = r_out_port;
  assign o_readdata   = r_readdata;
  assign o_pulse_busy = w_pulsing;

endmodule

// File: tb/tb_nios_pio_pulse_out.sv
// Directed bench for nios_pio_pulse_out with RESET_VALUE=A5, PULSE_CYCLES=4.
module tb_nios_pio_pulse_out;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        pulse_busy;

  int tests;
  int fails;

  nios_pio_pulse_out #(
    .DATA_WIDTH  (8),
    .RESET_VALUE (8'hA5),
    .PULSE_CYCLES(4),
    .CNT_WIDTH   (16)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_address   (address),
    .i_chipselect(chipselect),
    .i_write_n   (write_n),
    .i_writedata (writedata),
    .o_readdata  (readdata),
    .o_out_port  (out_port),
    .o_pulse_busy(pulse_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle write; outputs are checked #1 after the write edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // 1: reset values and DATA read latency
    #1;
    chk("rst_out", {24'h0, out_port}, 32'hA5);
    chk("rst_rd", readdata, 32'h0);
    chk("rst_busy", {31'h0, pulse_busy}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("rd_addr0", readdata, 32'hA5);

    // 2: DATA / OUTSET / OUTCLEAR and zero reads
    wr(2'd0, 32'hFFFF_FF0F);
    chk("data_wr", {24'h0, out_port}, 32'h0F);
    wr(2'd1, 32'h30);
    chk("outset_wr", {24'h0, out_port}, 32'h3F);
    wr(2'd2, 32'h03);
    chk("outclr_wr", {24'h0, out_port}, 32'h3C);
    address = 2'd1;
    tick();
    chk("rd_addr1", readdata, 32'h0);
    address = 2'd2;
    tick();
    chk("rd_addr2", readdata, 32'h0);

    // 3: single pulse, count readback 4,3,2,1,0
    wr(2'd3, 32'h01);
    chk("p_out0", {24'h0, out_port}, 32'h3D);
    chk("p_busy0", {31'h0, pulse_busy}, 32'h1);
    tick();
    chk("p_out1", {24'h0, out_port}, 32'h3D);
    chk("p_cnt4", readdata, 32'h8000_0004);
    tick();
    chk("p_cnt3", readdata, 32'h8000_0003);
    tick();
    chk("p_out3", {24'h0, out_port}, 32'h3D);
    chk("p_busy3", {31'h0, pulse_busy}, 32'h1);
    chk("p_cnt2", readdata, 32'h8000_0002);
    tick();
    chk("p_out4", {24'h0, out_port}, 32'h3C);
    chk("p_busy4", {31'h0, pulse_busy}, 32'h0);
    chk("p_cnt1", readdata, 32'h8000_0001);
    tick();
    chk("p_cnt0", readdata, 32'h0);

    // 4: retrigger two cycles after the first pulse
    wr(2'd3, 32'h01);
    tick();
    chk("rt_first", {24'h0, out_port}, 32'h3D);
    wr(2'd3, 32'h02);
    chk("rt_both", {24'h0, out_port}, 32'h3F);
    tick();
    tick();
    tick();
    chk("rt_hold", {24'h0, out_port}, 32'h3F);
    chk("rt_busy", {31'h0, pulse_busy}, 32'h1);
    tick();
    chk("rt_clear", {24'h0, out_port}, 32'h3C);
    chk("rt_idle", {31'h0, pulse_busy}, 32'h0);

    // 5: OUTCLEAR drains the mask and ends the pulse early
    wr(2'd3, 32'h03);
    chk("oc_set", {24'h0, out_port}, 32'h3F);
    wr(2'd2, 32'h01);
    chk("oc_bit0", {24'h0, out_port}, 32'h3E);
    chk("oc_busy", {31'h0, pulse_busy}, 32'h1);
    wr(2'd2, 32'h02);
    chk("oc_bit1", {24'h0, out_port}, 32'h3C);
    chk("oc_idle", {31'h0, pulse_busy}, 32'h0);
    address = 2'd3;
    tick();
    chk("oc_cnt", readdata, 32'h0);

    // DATA rewrite during a pulse: mask bit still clears at expiry
    wr(2'd3, 32'h40);
    chk("dw_set", {24'h0, out_port}, 32'h7C);
    wr(2'd0, 32'hFF);
    chk("dw_over", {24'h0, out_port}, 32'hFF);
    tick();
    tick();
    chk("dw_hold", {24'h0, out_port}, 32'hFF);
    tick();
    chk("dw_clr", {24'h0, out_port}, 32'hBF);

    // PULSE write exactly on the expiry edge
    wr(2'd0, 32'hF0);
    wr(2'd3, 32'h01);
    tick();
    tick();
    tick();
    chk("ex_pre", {24'h0, out_port}, 32'hF1);
    wr(2'd3, 32'h02);
    chk("ex_win", {24'h0, out_port}, 32'hF2);
    chk("ex_busy", {31'h0, pulse_busy}, 32'h1);
    tick();
    tick();
    tick();
    chk("ex_hold", {24'h0, out_port}, 32'hF2);
    tick();
    chk("ex_end", {24'h0, out_port}, 32'hF0);

    // 6: asynchronous reset mid-pulse
    wr(2'd3, 32'h04);
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_out", {24'h0, out_port}, 32'hA5);
    chk("ar_busy", {31'h0, pulse_busy}, 32'h0);
    chk("ar_rd", readdata, 32'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("ar_after", {24'h0, out_port}, 32'hA5);
    chk("ar_nobusy", {31'h0, pulse_busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
